instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
ID stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Decodes the fetched instruction and reads the 32x32 register file.
- Resolves branches and jumps in ID and drives the redirect and stall controls back to fetch.
- Registers operands and control into the ID/EX boundary for execute.
- Architectural branch delay slot: the instruction after a branch or jump always executes, so ID never flushes.

Parameters:
- NB_REG, 32, datapath/register width
- NB_INSTR, 32, instruction width
- N_REGS, 32, register file depth
- NB_REG_ADDR, 5, register address width
- NB_INM_I, 16, I-type immediate width
- NB_INM_J, 26, J-type target width
- NB_ALUOP, 4, ALU operation code width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  global step enable; when low, all state holds
- i_instr  in  NB_INSTR  instruction from fetch
- i_pc  in  NB_REG  pc+4 from fetch
- i_wb_en  in  1  writeback enable
- i_wb_addr  in  NB_REG_ADDR  writeback register
- i_wb_data  in  NB_REG  writeback data
- o_inm_i  out  NB_INM_I  instr[15:0] to fetch (combinational)
- o_inm_j  out  NB_INM_J  instr[25:0] to fetch (combinational)
- o_rs  out  NB_REG  bypassed rs value to fetch (combinational)
- o_branch, o_jump_inm, o_jump_rs  out  1 each  redirect to fetch (combinational)
- o_hazard  out  1  load-use stall to fetch (combinational)
- o_rs_data, o_rt_data  out  NB_REG  ID/EX operands
- o_inm_ext  out  NB_REG  sign- or zero-extended immediate
- o_rs_addr, o_rt_addr, o_dst_addr  out  NB_REG_ADDR  ID/EX register addresses
- o_pc  out  NB_REG  registered pc+4, used as link value
- o_alu_op  out  NB_ALUOP
- o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_link  out  1 each

Behaviour:
- All ID/EX outputs are registered. On reset, every registered output is 0.
- Register file: all entries cleared on reset.
  - Write on clock when i_wb_en, i_valid and i_wb_addr!=0. Register 0 always reads 0.
  - Read bypass: when wb_en and wb_addr equal a read address (nonzero), the read returns i_wb_data in the same cycle.
- Decoded classes and their effects:
  - R-type ALU: dst=rd, reg_write=1.
  - ADDI/SLTI/ANDI/ORI/XORI/LUI: dst=rt, alu_src=1. ANDI/ORI/XORI zero-extend; all others sign-extend.
  - LW/LH/LB/LBU/LHU: mem_read=1, mem_to_reg=1, reg_write=1.
  - SW/SH/SB: mem_write=1.
  - BEQ/BNE: no write.
  - J: o_jump_inm=1.
  - JAL: o_jump_inm=1, dst=31, link=1.
  - JR: o_jump_rs=1.
  - JALR: o_jump_rs=1, dst=rd, link=1.
  - Unknown opcode: bubble, with all control bits 0.
- Branch condition: o_branch=1 for BEQ with rs==rt, or BNE with rs!=rt. Compare uses the bypassed values.
- Hazard: o_hazard=1 when the registered ID/EX has mem_read=1 and o_dst_addr!=0 and it equals the current instruction's rs or rt (rt only when the instruction reads rt).
  - While o_hazard=1, o_branch, o_jump_inm and o_jump_rs are forced to 0. Fetch therefore sees a one-hot control vector.
  - While o_hazard=1, the ID/EX register loads a bubble (control 0, data don't-care, zeroed).
  - The stalled instruction is re-presented by fetch next cycle and decoded again.
- Redirect outputs: mutually exclusive by decode, and asserted only when i_valid=1.
- i_valid=0: ID/EX and register file hold; combinational outputs are still driven.
- Reset mid-stall: reset wins. ID/EX clears and o_hazard falls because mem_read=0.
- Latency: one clock from i_instr to the ID/EX outputs.

Decomposition:
- Shared package holds:
  - opcode and funct localparams (R-type=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, BNE=6'h05, J=6'h02, JAL=6'h03, JR funct=6'h08, JALR funct=6'h09)
  - ALU op encodings
  - register 31 constant
- Sub-module register_file handles storage, bypass and reset. Decode, hazard, branch compare and the ID/EX register live in the top.

Test Plan:
- Write r5=0x1234 via wb, then ADD r1,r5,r0 → next cycle o_rs_data=0x1234, o_dst_addr=1, reg_write=1. Same-cycle wb and read of r5 returns the wb data.
- BEQ r2,r3,+4 with r2=r3=7 → o_branch=1, o_inm_i=0x0004. With r3=8 → o_branch=0. BNE gives the opposite results.
- LW r4,0(r1) followed by ADD r6,r4,r2 → o_hazard=1 for exactly one cycle. The ID/EX bubble has all control 0. The ADD then issues with rs_addr=4.
- JAL 0x100 → o_jump_inm=1, o_inm_j=0x100. Next cycle: o_dst_addr=31, o_link=1, o_pc = the presented pc+4.
- JR r9 with r9=0x40 → o_jump_rs=1, o_rs=0x40. A write to r0 with data 0xFFFF leaves reads of r0 at 0.
- Assert reset during a hazard cycle → all outputs 0 next cycle, o_hazard=0. With i_valid=0, ID/EX holds its previous values.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// Shared encodings for the ID stage: MIPS opcode/funct values, ALU operation
// codes handed to execute, and the control bundle carried across ID/EX.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // Link register written by JAL
  localparam logic [4:0] REG_RA   = 5'd31;

  // ALU_FUNCT tells execute to decode the R-type funct field itself
  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_LUI   = 4'h6,
    ALU_FUNCT = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RT   = 2'd1,
    DST_RD   = 2'd2,
    DST_RA   = 2'd3
  } dst_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    link;
  } ex_ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file with writeback-to-read bypass; r0 is hardwired to 0.
module instruction_decode_register_file
#(
  parameter int NB_REG      = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5
)
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_wb_en,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]      i_wb_data,
  input  logic [NB_REG_ADDR-1:0] i_rs_addr,
  input  logic [NB_REG_ADDR-1:0] i_rt_addr,
  output logic [NB_REG-1:0]      o_rs_data,
  output logic [NB_REG-1:0]      o_rt_data
);

  logic [NB_REG-1:0] regs_q [N_REGS];
  logic [NB_REG-1:0] regs_d [N_REGS];

  // Next register contents: one write per step, never to r0
  always_comb begin
    regs_d = regs_q;
    if (i_valid && i_wb_en && (i_wb_addr != '0)) begin
      regs_d[i_wb_addr] = i_wb_data;
    end
  end

  // Storage, cleared by reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // A same-cycle writeback is forwarded so ID never sees a stale value
  assign o_rs_data = (i_rs_addr == '0) ? '0 :
                     (i_wb_en && (i_wb_addr == i_rs_addr)) ? i_wb_data : regs_q[i_rs_addr];
  assign o_rt_data = (i_rt_addr == '0) ? '0 :
                     (i_wb_en && (i_wb_addr == i_rt_addr)) ? i_wb_data : regs_q[i_rt_addr];

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: decode, register read, branch/jump resolution, load-use
// hazard detection and the ID/EX pipeline register.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_INSTR    = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_INM_I    = 16,
  parameter int NB_INM_J    = 26,
  parameter int NB_ALUOP    = 4
)
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_INSTR-1:0]    i_instr,
  input  logic [NB_REG-1:0]      i_pc,
  input  logic                   i_wb_en,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]      i_wb_data,
  output logic [NB_INM_I-1:0]    o_inm_i,
  output logic [NB_INM_J-1:0]    o_inm_j,
  output logic [NB_REG-1:0]      o_rs,
  output logic                   o_branch,
  output logic                   o_jump_inm,
  output logic                   o_jump_rs,
  output logic                   o_hazard,
  output logic [NB_REG-1:0]      o_rs_data,
  output logic [NB_REG-1:0]      o_rt_data,
  output logic [NB_REG-1:0]      o_inm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs_addr,
  output logic [NB_REG_ADDR-1:0] o_rt_addr,
  output logic [NB_REG_ADDR-1:0] o_dst_addr,
  output logic [NB_REG-1:0]      o_pc,
  output logic [NB_ALUOP-1:0]    o_alu_op,
  output logic                   o_alu_src,
  output logic                   o_reg_write,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_mem_to_reg,
  output logic                   o_link
);

  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [NB_REG_ADDR-1:0] rs_addr, rt_addr, rd_addr, dst_addr;
  logic [NB_INM_I-1:0]    inm;
  logic [NB_REG-1:0]      rs_val, rt_val, inm_ext;

  ex_ctrl_t dec_ctrl;
  dst_sel_e dst_sel;
  logic     reads_rt, zero_ext, is_beq, is_bne, dec_jump_inm, dec_jump_rs;
  logic     hazard, take_branch;

  logic [NB_REG-1:0]      rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [NB_REG-1:0]      inm_ext_q, inm_ext_d, pc_q, pc_d;
  logic [NB_REG_ADDR-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
  logic [NB_REG_ADDR-1:0] dst_addr_q, dst_addr_d;
  ex_ctrl_t               ctrl_q, ctrl_d;

  assign opcode  = i_instr[31:26];
  assign funct   = i_instr[5:0];
  assign rs_addr = i_instr[25:21];
  assign rt_addr = i_instr[20:16];
  assign rd_addr = i_instr[15:11];
  assign inm     = i_instr[NB_INM_I-1:0];

  instruction_decode_register_file #(
    .NB_REG      (NB_REG),
    .N_REGS      (N_REGS),
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_register_file (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_wb_en   (i_wb_en),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .o_rs_data (rs_val),
    .o_rt_data (rt_val)
  );

  // Opcode decode; anything unrecognised becomes a bubble
  always_comb begin
    dec_ctrl     = '0;
    dst_sel      = DST_NONE;
    reads_rt     = 1'b0;
    zero_ext     = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    dec_jump_inm = 1'b0;
    dec_jump_rs  = 1'b0;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_JR) begin
        dec_jump_rs = 1'b1;
      end else if (funct == FN_JALR) begin
        dec_jump_rs        = 1'b1;
        dec_ctrl.link      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dst_sel            = DST_RD;
      end else begin
        dec_ctrl.alu_op    = ALU_FUNCT;
        dec_ctrl.reg_write = 1'b1;
        dst_sel            = DST_RD;
        reads_rt           = 1'b1;
      end
    end else if (is_load(opcode)) begin
      dec_ctrl.alu_src    = 1'b1;
      dec_ctrl.mem_read   = 1'b1;
      dec_ctrl.mem_to_reg = 1'b1;
      dec_ctrl.reg_write  = 1'b1;
      dst_sel             = DST_RT;
    end else if (is_store(opcode)) begin
      dec_ctrl.alu_src   = 1'b1;
      dec_ctrl.mem_write = 1'b1;
      reads_rt           = 1'b1;
    end else begin
      case (opcode)
        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dst_sel            = DST_RT;
          zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
          case (opcode)
            OP_SLTI: dec_ctrl.alu_op = ALU_SLT;
            OP_ANDI: dec_ctrl.alu_op = ALU_AND;
            OP_ORI:  dec_ctrl.alu_op = ALU_OR;
            OP_XORI: dec_ctrl.alu_op = ALU_XOR;
            OP_LUI:  dec_ctrl.alu_op = ALU_LUI;
            default: dec_ctrl.alu_op = ALU_ADD;
          endcase
        end
        OP_BEQ, OP_BNE: begin
          dec_ctrl.alu_op = ALU_SUB;
          reads_rt        = 1'b1;
          is_beq          = (opcode == OP_BEQ);
          is_bne          = (opcode == OP_BNE);
        end
        OP_J: dec_jump_inm = 1'b1;
        OP_JAL: begin
          dec_jump_inm       = 1'b1;
          dec_ctrl.link      = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dst_sel            = DST_RA;
        end
        default: ;
      endcase
    end
  end

  // Destination selection and immediate extension
  always_comb begin
    case (dst_sel)
      DST_RT:  dst_addr = rt_addr;
      DST_RD:  dst_addr = rd_addr;
      DST_RA:  dst_addr = REG_RA;
      default: dst_addr = '0;
    endcase
    if (zero_ext) inm_ext = {{(NB_REG-NB_INM_I){1'b0}}, inm};
    else          inm_ext = {{(NB_REG-NB_INM_I){inm[NB_INM_I-1]}}, inm};
  end

  // A load in EX whose target feeds this instruction must stall one cycle
  assign hazard = ctrl_q.mem_read && (dst_addr_q != '0) &&
                  ((dst_addr_q == rs_addr) || (reads_rt && (dst_addr_q == rt_addr)));

  assign take_branch = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));

  assign o_inm_i    = inm;
  assign o_inm_j    = i_instr[NB_INM_J-1:0];
  assign o_rs       = rs_val;
  assign o_hazard   = hazard;
  assign o_branch   = i_valid && !hazard && take_branch;
  assign o_jump_inm = i_valid && !hazard && dec_jump_inm;
  assign o_jump_rs  = i_valid && !hazard && dec_jump_rs;

  // ID/EX next state: hold when not stepping, bubble on stall, else load
  always_comb begin
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    inm_ext_d  = inm_ext_q;
    pc_d       = pc_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    dst_addr_d = dst_addr_q;
    ctrl_d     = ctrl_q;
    if (i_valid) begin
      if (hazard) begin
        rs_data_d  = '0;
        rt_data_d  = '0;
        inm_ext_d  = '0;
        pc_d       = '0;
        rs_addr_d  = '0;
        rt_addr_d  = '0;
        dst_addr_d = '0;
        ctrl_d     = '0;
      end else begin
        rs_data_d  = rs_val;
        rt_data_d  = rt_val;
        inm_ext_d  = inm_ext;
        pc_d       = i_pc;
        rs_addr_d  = rs_addr;
        rt_addr_d  = rt_addr;
        dst_addr_d = dst_addr;
        ctrl_d     = dec_ctrl;
      end
    end
  end

  // ID/EX boundary register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      inm_ext_q  <= '0;
      pc_q       <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      dst_addr_q <= '0;
      ctrl_q     <= '0;
    end else begin
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      inm_ext_q  <= inm_ext_d;
      pc_q       <= pc_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      dst_addr_q <= dst_addr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign o_rs_data    = rs_data_q;
  assign o_rt_data    = rt_data_q;
  assign o_inm_ext    = inm_ext_q;
  assign o_pc         = pc_q;
  assign o_rs_addr    = rs_addr_q;
  assign o_rt_addr    = rt_addr_q;
  assign o_dst_addr   = dst_addr_q;
  assign o_alu_op     = NB_ALUOP'(ctrl_q.alu_op);
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_link       = ctrl_q.link;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for the ID stage: stimulus pushes expected responses from
// an architectural model, a monitor pops and compares each cycle.
module tb_instruction_decode;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04, T_BNE = 6'h05;
  localparam logic [5:0] T_LW = 6'h23, T_ADDI = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20, F_JR = 6'h08, F_JALR = 6'h09;

  logic        i_clock = 1'b0;
  logic        i_reset, i_valid, i_wb_en;
  logic [31:0] i_instr, i_pc, i_wb_data;
  logic [4:0]  i_wb_addr;
  logic [15:0] o_inm_i;
  logic [25:0] o_inm_j;
  logic [31:0] o_rs, o_rs_data, o_rt_data, o_inm_ext, o_pc;
  logic        o_branch, o_jump_inm, o_jump_rs, o_hazard;
  logic [4:0]  o_rs_addr, o_rt_addr, o_dst_addr;
  logic [3:0]  o_alu_op;
  logic        o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_link;

  instruction_decode dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_inm_i(o_inm_i), .o_inm_j(o_inm_j), .o_rs(o_rs), .o_branch(o_branch),
    .o_jump_inm(o_jump_inm), .o_jump_rs(o_jump_rs), .o_hazard(o_hazard),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_inm_ext(o_inm_ext),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_dst_addr(o_dst_addr), .o_pc(o_pc),
    .o_alu_op(o_alu_op), .o_alu_src(o_alu_src), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_link(o_link)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] rs_data, rt_data, inm_ext, pc;
    logic [4:0]  rs_a, rt_a, dst;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, link;
  } idex_t;

  typedef struct packed {
    logic [3:0]  redir;   // hazard, branch, jump_inm, jump_rs
    logic [31:0] rs;
    logic [15:0] inm_i;
    logic [25:0] inm_j;
    idex_t       idex;
  } exp_t;

  typedef struct packed {
    logic alu_src, reg_write, mem_read, mem_write, mem_to_reg, link;
    logic jinm, jrs, beq, bne, reads_rt, zext;
    logic [1:0] dsel;     // 0 none, 1 rt, 2 rd, 3 r31
  } dec_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  idex_t       m;
  int          tests = 0;
  int          fails = 0;

  // Architectural meaning of each instruction class
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == F_JR) d.jrs = 1'b1;
        else if (ins[5:0] == F_JALR) begin d.jrs = 1'b1; d.link = 1'b1; d.reg_write = 1'b1; d.dsel = 2'd2; end
        else begin d.reg_write = 1'b1; d.dsel = 2'd2; d.reads_rt = 1'b1; end
      end
      6'h08, 6'h0A, 6'h0F: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.dsel = 2'd1; end
      6'h0C, 6'h0D, 6'h0E: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.dsel = 2'd1; d.zext = 1'b1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d.alu_src = 1'b1; d.mem_read = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1; d.dsel = 2'd1;
      end
      6'h28, 6'h29, 6'h2B: begin d.alu_src = 1'b1; d.mem_write = 1'b1; d.reads_rt = 1'b1; end
      6'h04: begin d.beq = 1'b1; d.reads_rt = 1'b1; end
      6'h05: begin d.bne = 1'b1; d.reads_rt = 1'b1; end
      6'h02: d.jinm = 1'b1;
      6'h03: begin d.jinm = 1'b1; d.link = 1'b1; d.reg_write = 1'b1; d.dsel = 2'd3; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic [31:0] rt_i(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {T_R, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
    tests++;
    if (act !== exv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exv);
    end
  endtask

  // Drive one cycle and push the model's expectation for it
  task automatic step(input logic rst, input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dec_t        d;
    exp_t        e;
    logic [31:0] rsv, rtv;
    logic [4:0]  rs, rt;
    logic        haz;
    @(negedge i_clock);
    i_reset = rst; i_valid = vld; i_instr = ins; i_pc = pc;
    i_wb_en = we; i_wb_addr = wa; i_wb_data = wd;
    rs = ins[25:21];
    rt = ins[20:16];
    d = decode(ins);
    rsv = rd_model(rs, we, wa, wd);
    rtv = rd_model(rt, we, wa, wd);
    haz = m.mem_read && (m.dst != 5'd0) && ((m.dst == rs) || (d.reads_rt && m.dst == rt));
    e.redir = {haz,
               vld && !haz && ((d.beq && rsv == rtv) || (d.bne && rsv != rtv)),
               vld && !haz && d.jinm,
               vld && !haz && d.jrs};
    e.rs    = rsv;
    e.inm_i = ins[15:0];
    e.inm_j = ins[25:0];
    if (rst) begin
      m = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (vld) begin
      if (we && wa != 5'd0) mregs[wa] = wd;
      if (haz) m = '0;
      else begin
        m.rs_data = rsv;
        m.rt_data = rtv;
        m.inm_ext = d.zext ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        m.pc      = pc;
        m.rs_a    = rs;
        m.rt_a    = rt;
        case (d.dsel)
          2'd1:    m.dst = rt;
          2'd2:    m.dst = ins[15:11];
          2'd3:    m.dst = 5'd31;
          default: m.dst = 5'd0;
        endcase
        m.alu_src = d.alu_src; m.reg_write = d.reg_write; m.mem_read = d.mem_read;
        m.mem_write = d.mem_write; m.mem_to_reg = d.mem_to_reg; m.link = d.link;
      end
    end
    e.idex = m;
    q.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, ID/EX just after the edge
  initial begin
    exp_t cur;
    forever begin
      @(negedge i_clock);
      #2;
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("redirect_hazard", 64'({o_hazard, o_branch, o_jump_inm, o_jump_rs}), 64'(cur.redir));
        chk("o_rs", 64'(o_rs), 64'(cur.rs));
        chk("o_inm", 64'({o_inm_i, o_inm_j}), 64'({cur.inm_i, cur.inm_j}));
        @(posedge i_clock);
        #1;
        chk("idex_operands", {o_rs_data, o_rt_data}, {cur.idex.rs_data, cur.idex.rt_data});
        chk("idex_imm_pc", {o_inm_ext, o_pc}, {cur.idex.inm_ext, cur.idex.pc});
        chk("idex_addr_ctrl",
            64'({o_rs_addr, o_rt_addr, o_dst_addr, o_alu_src, o_reg_write, o_mem_read,
                 o_mem_write, o_mem_to_reg, o_link}),
            64'({cur.idex.rs_a, cur.idex.rt_a, cur.idex.dst, cur.idex.alu_src, cur.idex.reg_write,
                 cur.idex.mem_read, cur.idex.mem_write, cur.idex.mem_to_reg, cur.idex.link}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0]  ops [24] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                            6'h20, 6'h21, 6'h23, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                            6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h11};
  logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h08, 6'h09};

  initial begin
    logic [31:0] ins;
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    i_reset = 1'b1; i_valid = 1'b0; i_instr = '0; i_pc = '0;
    i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    repeat (2) @(posedge i_clock);

    step(1, 1, 32'h0, 32'h0, 0, 0, 0);                          // reset state
    step(0, 1, 32'h0, 32'h4, 1, 5, 32'h1234);                   // r5 = 0x1234
    step(0, 1, rt_i(5, 0, 1, F_ADD), 32'h8, 0, 0, 0);           // ADD r1,r5,r0
    step(0, 1, rt_i(5, 0, 1, F_ADD), 32'hC, 1, 5, 32'h5678);    // same-cycle bypass
    step(0, 1, 32'h0, 32'h10, 1, 2, 32'd7);
    step(0, 1, 32'h0, 32'h14, 1, 3, 32'd7);
    step(0, 1, it_i(T_BEQ, 2, 3, 16'h0004), 32'h18, 0, 0, 0);   // taken
    step(0, 1, it_i(T_BNE, 2, 3, 16'h0004), 32'h1C, 0, 0, 0);   // not taken
    step(0, 1, 32'h0, 32'h20, 1, 3, 32'd8);
    step(0, 1, it_i(T_BEQ, 2, 3, 16'h0004), 32'h24, 0, 0, 0);   // not taken
    step(0, 1, it_i(T_BNE, 2, 3, 16'h0004), 32'h28, 0, 0, 0);   // taken
    step(0, 1, 32'h0, 32'h2C, 1, 1, 32'h100);
    step(0, 1, it_i(T_LW, 1, 4, 16'h0), 32'h30, 0, 0, 0);       // LW r4,0(r1)
    step(0, 1, rt_i(4, 2, 6, F_ADD), 32'h34, 0, 0, 0);          // stalls
    step(0, 1, rt_i(4, 2, 6, F_ADD), 32'h34, 0, 0, 0);          // issues
    step(0, 1, {T_JAL, 26'h100}, 32'h2004, 0, 0, 0);            // JAL 0x100
    step(0, 1, 32'h0, 32'h2008, 1, 9, 32'h40);
    step(0, 1, rt_i(9, 0, 0, F_JR), 32'h200C, 0, 0, 0);         // JR r9
    step(0, 1, rt_i(0, 0, 7, F_ADD), 32'h2010, 1, 0, 32'hFFFF); // write to r0 ignored
    step(0, 1, rt_i(0, 0, 7, F_ADD), 32'h2014, 0, 0, 0);
    step(0, 1, rt_i(9, 0, 10, F_JALR), 32'h2018, 0, 0, 0);      // JALR r10,r9
    step(0, 1, it_i(T_LW, 1, 4, 16'h0), 32'h30, 0, 0, 0);
    step(1, 1, rt_i(4, 2, 6, F_ADD), 32'h34, 0, 0, 0);          // reset during stall
    step(0, 1, rt_i(4, 2, 6, F_ADD), 32'h34, 0, 0, 0);
    step(0, 1, it_i(T_ADDI, 0, 3, 16'h8055), 32'h40, 0, 0, 0);
    step(0, 0, it_i(T_LW, 1, 4, 16'h0), 32'h44, 1, 3, 32'hABCD); // hold
    step(0, 0, {T_J, 26'h3}, 32'h48, 0, 0, 0);                  // no redirect when idle
    step(0, 1, rt_i(3, 0, 8, F_ADD), 32'h4C, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 23)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 5)];
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, ins, $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom);
    end

    repeat (3) @(negedge i_clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
